// File: rtl/ex_completion_scheduler.sv
// ex_completion_scheduler
//
// Execute-stage writeback-slot scheduler. Each issued instruction reserves
// the single writeback slot its (clamped) latency lands on. Reservations
// slide one slot toward the output register on every cycle in which the
// output side can move. A collision with an existing reservation, or a
// frozen output, stalls the ID/EX latch combinationally. Completions leave
// through a valid/ready handshake in landing order.
//
// Optional feature: define EX_SCHED_STATS_EN to add two free-running 32-bit
// counters: stall cycles, and conflict-only stall cycles. in_flush does not
// clear these counters.
module ex_completion_scheduler #(
  parameter int MAX_LAT        = 15,
  parameter int CNT_W          = 5,
  parameter int ROB_ID_SIZE    = 6,
  parameter int DEST_ADDR_SIZE = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_flush,
  input  logic                      in_ins_nop,
  input  logic [ROB_ID_SIZE-1:0]    in_ins_id,
  input  logic [DEST_ADDR_SIZE-1:0] in_dest_addr,
  input  logic [2:0]                in_func_select,
  input  logic [3:0]                in_latency,
  input  logic                      wb_ready,
  output logic                      out_stall,
  output logic                      out_valid,
  output logic [ROB_ID_SIZE-1:0]    out_ins_id,
  output logic [DEST_ADDR_SIZE-1:0] out_dest_addr,
  output logic [2:0]                out_func_select,
  output logic [CNT_W-1:0]          out_inflight
`ifdef EX_SCHED_STATS_EN
  ,
  output logic [31:0]               out_stall_cycles,
  output logic [31:0]               out_conflict_cycles
`endif
);

  localparam logic [3:0] MAX_LAT_L = 4'(MAX_LAT);

  // A zero latency still needs one cycle; anything deeper than the table
  // lands in the deepest slot.
  function automatic logic [3:0] eff_latency(input logic [3:0] lat);
    logic [3:0] res;
    if (lat == 4'd0) begin
      res = 4'd1;
    end else if (lat > MAX_LAT_L) begin
      res = MAX_LAT_L;
    end else begin
      res = lat;
    end
    return res;
  endfunction

  // Reservation table; index i means "reaches the output register after i
  // more advancing edges".
  logic [MAX_LAT:1]                     slot_valid_r;
  logic [MAX_LAT:1][ROB_ID_SIZE-1:0]    slot_id_r;
  logic [MAX_LAT:1][DEST_ADDR_SIZE-1:0] slot_dest_r;
  logic [MAX_LAT:1][2:0]                slot_func_r;

  logic [MAX_LAT:1]                     slot_valid_nxt_s;
  logic [MAX_LAT:1][ROB_ID_SIZE-1:0]    slot_id_nxt_s;
  logic [MAX_LAT:1][DEST_ADDR_SIZE-1:0] slot_dest_nxt_s;
  logic [MAX_LAT:1][2:0]                slot_func_nxt_s;

  logic [MAX_LAT:1]                     slot_valid_sh_s;
  logic [MAX_LAT:1][ROB_ID_SIZE-1:0]    slot_id_sh_s;
  logic [MAX_LAT:1][DEST_ADDR_SIZE-1:0] slot_dest_sh_s;
  logic [MAX_LAT:1][2:0]                slot_func_sh_s;

  logic [MAX_LAT:1] land_sel_s;
  logic [3:0]       leff_s;
  logic             advance_s;
  logic             conflict_s;
  logic             accept_s;
  logic             handoff_s;

  // Issue decision: clamp latency, detect slot collision and output freeze.
  always_comb begin
    leff_s     = eff_latency(in_latency);
    advance_s  = !(out_valid && !wb_ready);
    conflict_s = 1'b0;
    // After this edge slot[i+1] shifts into slot[i], so it is the one that
    // would collide with a new entry of latency i. The deepest slot never
    // collides because nothing sits above it.
    for (int i = 1; i < MAX_LAT; i++) begin
      conflict_s = conflict_s | ((leff_s == 4'(i)) & slot_valid_r[i+1]);
    end
    out_stall = !in_flush && !in_ins_nop && (!advance_s || conflict_s);
    accept_s  = !in_flush && !in_ins_nop && !out_stall;
    handoff_s = out_valid && wb_ready;
  end

  // Next table contents on an advancing edge: shift toward slot 1, then drop
  // the accepted instruction into its landing slot.
  always_comb begin
    slot_valid_sh_s = slot_valid_r >> 1;
    slot_id_sh_s    = slot_id_r >> ROB_ID_SIZE;
    slot_dest_sh_s  = slot_dest_r >> DEST_ADDR_SIZE;
    slot_func_sh_s  = slot_func_r >> 3;
    for (int i = 1; i <= MAX_LAT; i++) begin
      land_sel_s[i]       = accept_s && (leff_s == 4'(i));
      slot_valid_nxt_s[i] = land_sel_s[i] ? 1'b1           : slot_valid_sh_s[i];
      slot_id_nxt_s[i]    = land_sel_s[i] ? in_ins_id      : slot_id_sh_s[i];
      slot_dest_nxt_s[i]  = land_sel_s[i] ? in_dest_addr   : slot_dest_sh_s[i];
      slot_func_nxt_s[i]  = land_sel_s[i] ? in_func_select : slot_func_sh_s[i];
    end
  end

  // Reservation table and output register; flush wins, a frozen output holds all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid_r    <= '0;
      slot_id_r       <= '0;
      slot_dest_r     <= '0;
      slot_func_r     <= '0;
      out_valid       <= 1'b0;
      out_ins_id      <= '0;
      out_dest_addr   <= '0;
      out_func_select <= 3'd0;
    end else if (in_flush) begin
      slot_valid_r <= '0;
      out_valid    <= 1'b0;
    end else if (advance_s) begin
      slot_valid_r    <= slot_valid_nxt_s;
      slot_id_r       <= slot_id_nxt_s;
      slot_dest_r     <= slot_dest_nxt_s;
      slot_func_r     <= slot_func_nxt_s;
      out_valid       <= slot_valid_r[1];
      out_ins_id      <= slot_id_r[1];
      out_dest_addr   <= slot_dest_r[1];
      out_func_select <= slot_func_r[1];
    end
  end

  // In-flight count: occupied slots plus a pending output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_inflight <= '0;
    end else if (in_flush) begin
      out_inflight <= '0;
    end else begin
      case ({accept_s, handoff_s})
        2'b10:   out_inflight <= out_inflight + CNT_W'(1);
        2'b01:   out_inflight <= out_inflight - CNT_W'(1);
        default: out_inflight <= out_inflight;
      endcase
    end
  end

`ifdef EX_SCHED_STATS_EN
  // Stall statistics; free-running, survive flush, wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_stall_cycles    <= 32'd0;
      out_conflict_cycles <= 32'd0;
    end else begin
      if (out_stall) begin
        out_stall_cycles <= out_stall_cycles + 32'd1;
      end
      if (out_stall && conflict_s && advance_s) begin
        out_conflict_cycles <= out_conflict_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_completion_scheduler.sv
// Self-checking bench for ex_completion_scheduler (MAX_LAT=8).
// The reference model keeps pending instructions as a queue tagged with the
// absolute "advance tick" on which each reaches the output register.
module tb_ex_completion_scheduler;

  localparam int MAXL = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_flush = 1'b0;
  logic       in_ins_nop = 1'b1;
  logic [5:0] in_ins_id = 6'd0;
  logic [5:0] in_dest_addr = 6'd0;
  logic [2:0] in_func_select = 3'd0;
  logic [3:0] in_latency = 4'd0;
  logic       wb_ready = 1'b1;
  logic       out_stall, out_valid;
  logic [5:0] out_ins_id, out_dest_addr;
  logic [2:0] out_func_select;
  logic [4:0] out_inflight;
`ifdef EX_SCHED_STATS_EN
  logic [31:0] out_stall_cycles, out_conflict_cycles;
`endif

  ex_completion_scheduler #(
    .MAX_LAT(MAXL), .CNT_W(5), .ROB_ID_SIZE(6), .DEST_ADDR_SIZE(6)
  ) dut (
    .clk(clk), .reset(reset), .in_flush(in_flush), .in_ins_nop(in_ins_nop),
    .in_ins_id(in_ins_id), .in_dest_addr(in_dest_addr),
    .in_func_select(in_func_select), .in_latency(in_latency),
    .wb_ready(wb_ready), .out_stall(out_stall), .out_valid(out_valid),
    .out_ins_id(out_ins_id), .out_dest_addr(out_dest_addr),
    .out_func_select(out_func_select), .out_inflight(out_inflight)
`ifdef EX_SCHED_STATS_EN
    , .out_stall_cycles(out_stall_cycles), .out_conflict_cycles(out_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         land;
    logic [5:0] id;
    logic [5:0] dest;
    logic [2:0] func;
  } item_t;

  item_t       pend[$];
  int          m_tick;
  logic        m_ov;
  logic [5:0]  m_id, m_dest;
  logic [2:0]  m_func;
  int          m_infl;
  logic [31:0] m_sc, m_cc;
  logic        last_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_tick = 0;
    m_ov = 1'b0;
    m_id = 6'd0;
    m_dest = 6'd0;
    m_func = 3'd0;
    m_infl = 0;
    m_sc = 32'd0;
    m_cc = 32'd0;
  endtask

  // One clock: drive at negedge, compare just after, advance model at posedge.
  task automatic cycle(input logic f, input logic nop, input logic [5:0] id,
                       input logic [5:0] dest, input logic [2:0] func,
                       input logic [3:0] lat, input logic rdy);
    int    leff;
    logic  adv, conf, stall, acc, hand;
    item_t it;
    @(negedge clk);
    in_flush = f; in_ins_nop = nop; in_ins_id = id; in_dest_addr = dest;
    in_func_select = func; in_latency = lat; wb_ready = rdy;
    #1;
    leff = (lat == 4'd0) ? 1 : ((int'(lat) > MAXL) ? MAXL : int'(lat));
    adv  = !(m_ov && !rdy);
    conf = 1'b0;
    foreach (pend[i]) if (pend[i].land - m_tick == leff + 1) conf = 1'b1;
    stall = !f && !nop && (!adv || conf);
    acc   = !f && !nop && !stall;
    hand  = m_ov && rdy;
    check("stall", out_stall, stall);
    check("valid", out_valid, m_ov);
    check("inflight", out_inflight, m_infl);
    if (m_ov) begin
      check("id", out_ins_id, m_id);
      check("dest", out_dest_addr, m_dest);
      check("func", out_func_select, m_func);
    end
`ifdef EX_SCHED_STATS_EN
    check("stall_cycles", out_stall_cycles, m_sc);
    check("conflict_cycles", out_conflict_cycles, m_cc);
`endif
    last_stall = out_stall;
    @(posedge clk);
    if (stall) m_sc = m_sc + 32'd1;
    if (stall && conf && adv) m_cc = m_cc + 32'd1;
    if (f) begin
      pend.delete();
      m_ov = 1'b0;
      m_infl = 0;
    end else if (adv) begin
      m_ov = 1'b0;
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].land == m_tick + 1) begin
          m_ov = 1'b1; m_id = pend[i].id; m_dest = pend[i].dest; m_func = pend[i].func;
          pend.delete(i);
          break;
        end
      end
      m_tick++;
      if (acc) begin
        it.land = m_tick + leff; it.id = id; it.dest = dest; it.func = func;
        pend.push_back(it);
      end
      m_infl = m_infl + (acc ? 1 : 0) - (hand ? 1 : 0);
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b1, 6'd0, 6'd0, 3'd0, 4'd0, rdy);
  endtask

  task automatic issue(input logic [5:0] id, input logic [5:0] dest,
                       input logic [2:0] func, input logic [3:0] lat);
    cycle(1'b0, 1'b0, id, dest, func, lat, 1'b1);
  endtask

  // Counts edges until out_valid rises, bounded.
  task automatic edges_to_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      idle(1'b1);
      n++;
    end
  endtask

  logic [5:0] r_id, r_dest;
  logic [2:0] r_func;
  logic [3:0] r_lat;
  logic       r_nop, r_f, r_rdy;
  int         n;

  initial begin
    model_reset();
    // Reset values, with a non-NOP instruction presented.
    in_ins_nop = 1'b0; in_latency = 4'd3; in_ins_id = 6'd9;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_id", out_ins_id, 6'd0);
    check("rst_dest", out_dest_addr, 6'd0);
    check("rst_func", out_func_select, 3'd0);
    check("rst_inflight", out_inflight, 5'd0);
    check("rst_stall", out_stall, 1'b0);
    in_ins_nop = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // Single issue: id 5, dest 7, latency 3.
    idle(1'b1);
    issue(6'd5, 6'd7, 3'd2, 4'd3);
    check("single_infl1", out_inflight, 5'd1);
    edges_to_valid(n);
    check("single_edges", n, 3);
    check("single_id", out_ins_id, 6'd5);
    check("single_dest", out_dest_addr, 6'd7);
    idle(1'b1);
    check("single_drop", out_valid, 1'b0);
    check("single_infl0", out_inflight, 5'd0);

    // Slot conflict: L3 then L2 collide.
    issue(6'd1, 6'd1, 3'd0, 4'd3);
    issue(6'd2, 6'd2, 3'd0, 4'd2);
    check("conflict_stall", last_stall, 1'b1);
    issue(6'd2, 6'd2, 3'd0, 4'd2);
    check("conflict_accept", last_stall, 1'b0);
    idle(1'b1);
    check("conflict_first", {out_valid, out_ins_id}, {1'b1, 6'd1});
    idle(1'b1);
    check("conflict_second", {out_valid, out_ins_id}, {1'b1, 6'd2});
    idle(1'b1);
    check("conflict_done", out_valid, 1'b0);

    // Backpressure: 4 frozen cycles shift the next completion by 4.
    issue(6'd3, 6'd3, 3'd1, 4'd2);
    issue(6'd4, 6'd4, 3'd1, 4'd3);
    idle(1'b1);
    check("bp_first", {out_valid, out_ins_id}, {1'b1, 6'd3});
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 6'd9, 6'd9, 3'd0, 4'd1, 1'b0);
      check("bp_stall", last_stall, 1'b1);
      check("bp_hold", {out_valid, out_ins_id}, {1'b1, 6'd3});
    end
    idle(1'b1);
    check("bp_gap", out_valid, 1'b0);
    idle(1'b1);
    check("bp_second", {out_valid, out_ins_id}, {1'b1, 6'd4});
    idle(1'b1);
    idle(1'b1);

    // Latency clamping.
    issue(6'd6, 6'd6, 3'd0, 4'd0);
    edges_to_valid(n);
    check("clamp_lat0", n, 1);
    idle(1'b1);
    idle(1'b1);
    issue(6'd7, 6'd7, 3'd0, 4'd12);
    edges_to_valid(n);
    check("clamp_lat12", n, 8);
    check("clamp_id", out_ins_id, 6'd7);
    idle(1'b1);

    // Flush with three in flight.
    issue(6'd10, 6'd10, 3'd3, 4'd4);
    issue(6'd11, 6'd11, 3'd3, 4'd5);
    issue(6'd12, 6'd12, 3'd3, 4'd6);
    check("flush_pre_infl", out_inflight, 5'd3);
    cycle(1'b1, 1'b0, 6'd13, 6'd13, 3'd0, 4'd2, 1'b1);
    check("flush_stall", last_stall, 1'b0);
    check("flush_infl", out_inflight, 5'd0);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check("flush_quiet", out_valid, 1'b0);
    end

    // Randomized traffic; a stalled instruction is held like a real latch.
    last_stall = 1'b0;
    r_id = 6'd0; r_dest = 6'd0; r_func = 3'd0; r_lat = 4'd0; r_nop = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!last_stall) begin
        r_nop  = ($urandom_range(0, 3) == 0);
        r_id   = 6'($urandom);
        r_dest = 6'($urandom);
        r_func = 3'($urandom);
        r_lat  = 4'($urandom_range(0, 15));
      end
      r_f   = ($urandom_range(0, 39) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      cycle(r_f, r_nop, r_id, r_dest, r_func, r_lat, r_rdy);
    end

    // Asynchronous reset mid-cycle with work pending.
    issue(6'd20, 6'd20, 3'd1, 4'd5);
    issue(6'd21, 6'd21, 3'd1, 4'd2);
    check("areset_pre", (out_inflight != 5'd0), 1'b1);
    #2;
    in_ins_nop = 1'b0; in_latency = 4'd2;
    reset = 1'b0;
    #1;
    check("areset_valid", out_valid, 1'b0);
    check("areset_id", out_ins_id, 6'd0);
    check("areset_dest", out_dest_addr, 6'd0);
    check("areset_func", out_func_select, 3'd0);
    check("areset_infl", out_inflight, 5'd0);
    check("areset_stall", out_stall, 1'b0);
`ifdef EX_SCHED_STATS_EN
    check("areset_sc", out_stall_cycles, 32'd0);
    check("areset_cc", out_conflict_cycles, 32'd0);
`endif
    model_reset();
    in_ins_nop = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      check("areset_quiet", out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
